// File: rtl/pb_bus_pkg.sv
// Shared types and elaboration-time helpers for the peripheral-bus sequencer.
package pb_bus_pkg;

  typedef enum logic [1:0] {
    OP_WRITE = 2'b00,
    OP_READ  = 2'b01,
    OP_TEST  = 2'b10,
    OP_BCAST = 2'b11
  } pb_op_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_ADDR,
    S_SETUP,
    S_STROBE,
    S_HOLD,
    S_NEXT,
    S_DONE
  } pb_seq_state_t;

  // Bus strobes are active low.
  localparam logic ENABLE  = 1'b0;
  localparam logic DISABLE = 1'b1;

  function automatic int unsigned ns_to_cycles(input longint unsigned ns,
                                               input longint unsigned freq);
    longint unsigned num;
    num = ns * freq + 64'd999_999_999;
    return 32'(num / 64'd1_000_000_000);
  endfunction

  function automatic int unsigned at_least_one(input int unsigned cyc);
    return (cyc == 0) ? 1 : cyc;
  endfunction

endpackage

// File: rtl/pb_phase_timer.sv
// Loadable down-counter shared by all timed bus phases; done while count is zero.
module pb_phase_timer #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic             done
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clock or posedge reset) begin
    if (reset)              count <= '0;
    else if (load)          count <= load_value;
    else if (count != '0)   count <= count - 1'b1;
  end

  assign done = (count == '0);

endmodule

// File: rtl/pb_bus_sequencer.sv
// Walks a board mask in ascending order, running one timed bus slot per board,
// and returns all sampled read lanes in a single response.
module pb_bus_sequencer
  import pb_bus_pkg::*;
#(
  parameter int unsigned CLOCK_FREQUENCY = 27000000,
  parameter int unsigned NUM_BOARDS      = 4,
  parameter int unsigned DATA_WIDTH      = 8,
  parameter int unsigned ADDR_WIDTH      = 3,
  parameter int unsigned PRE_DELAY_NS    = 0,
  parameter int unsigned SETUP_NS        = 750,
  parameter int unsigned STROBE_NS       = 750,
  parameter int unsigned HOLD_NS         = 100
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             cmd_valid,
  output logic                             cmd_ready,
  input  logic [1:0]                       cmd_op,
  input  logic [ADDR_WIDTH-1:0]            cmd_addr,
  input  logic [NUM_BOARDS-1:0]            cmd_mask,
  input  logic [NUM_BOARDS*DATA_WIDTH-1:0] cmd_wdata,
  output logic                             rsp_valid,
  output logic [NUM_BOARDS*DATA_WIDTH-1:0] rsp_data,
  output logic [$clog2(NUM_BOARDS+1)-1:0]  rsp_count,
  output logic                             busy,
  output logic [NUM_BOARDS-1:0]            board_sel,
  output logic [ADDR_WIDTH-1:0]            addr_port,
  output logic                             test_addr,
  output logic                             pb_rd_n,
  output logic                             pb_wr_n,
  output logic [DATA_WIDTH-1:0]            data_out,
  input  logic [DATA_WIDTH-1:0]            data_in,
  output logic                             data_oe
);

  localparam int unsigned PRE_CYC    = ns_to_cycles(PRE_DELAY_NS, CLOCK_FREQUENCY);
  localparam int unsigned SETUP_CYC  = at_least_one(ns_to_cycles(SETUP_NS, CLOCK_FREQUENCY));
  localparam int unsigned STROBE_CYC = at_least_one(ns_to_cycles(STROBE_NS, CLOCK_FREQUENCY));
  localparam int unsigned HOLD_CYC   = at_least_one(ns_to_cycles(HOLD_NS, CLOCK_FREQUENCY));
  localparam int unsigned MAX_A      = (SETUP_CYC > STROBE_CYC) ? SETUP_CYC : STROBE_CYC;
  localparam int unsigned MAX_B      = (HOLD_CYC > PRE_CYC) ? HOLD_CYC : PRE_CYC;
  localparam int unsigned MAX_CYC    = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int unsigned TW         = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam int unsigned IDXW       = (NUM_BOARDS > 1) ? $clog2(NUM_BOARDS) : 1;
  localparam int unsigned CW         = $clog2(NUM_BOARDS + 1);
  localparam int unsigned PRE_LOAD   = (PRE_CYC > 0) ? PRE_CYC - 1 : 0;

  pb_seq_state_t state, state_next;
  pb_op_t                          op_q;
  logic [ADDR_WIDTH-1:0]           addr_q;
  logic [NUM_BOARDS-1:0]           mask_q, pending, pending_rest, cur_onehot;
  logic [NUM_BOARDS*DATA_WIDTH-1:0] wdata_q;
  logic [IDXW-1:0]                 cur;
  logic                            cur_found;
  logic [CW-1:0]                   mask_pop;
  logic [DATA_WIDTH-1:0]           lane_data;
  logic                            accept, in_slot, is_write, is_read;
  logic                            tmr_load, tmr_done;
  logic [TW-1:0]                   tmr_value;

  pb_phase_timer #(.WIDTH(TW)) u_timer (
    .clock      (clock),
    .reset      (reset),
    .load       (tmr_load),
    .load_value (tmr_value),
    .done       (tmr_done)
  );

  assign accept = cmd_valid && cmd_ready;

  // Current board is always the lowest bit still pending; it is retired in NEXT.
  always_comb begin
    cur       = '0;
    cur_found = 1'b0;
    for (int unsigned i = 0; i < NUM_BOARDS; i++) begin
      if (pending[i] && !cur_found) begin
        cur       = IDXW'(i);
        cur_found = 1'b1;
      end
    end
    cur_onehot   = NUM_BOARDS'(1) << cur;
    pending_rest = pending & ~cur_onehot;
  end

  always_comb begin
    mask_pop = '0;
    for (int unsigned i = 0; i < NUM_BOARDS; i++) mask_pop = mask_pop + CW'(cmd_mask[i]);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    tmr_load   = 1'b0;
    tmr_value  = '0;
    case (state)
      S_IDLE: begin
        if (accept) begin
          if (cmd_mask == '0) begin
            state_next = S_DONE;
          end else if (PRE_CYC > 0) begin
            state_next = S_PRE;
            tmr_load   = 1'b1;
            tmr_value  = TW'(PRE_LOAD);
          end else begin
            state_next = S_ADDR;
          end
        end
      end
      S_PRE:    if (tmr_done) state_next = S_ADDR;
      S_ADDR: begin
        state_next = S_SETUP;
        tmr_load   = 1'b1;
        tmr_value  = TW'(SETUP_CYC - 1);
      end
      S_SETUP: if (tmr_done) begin
        state_next = S_STROBE;
        tmr_load   = 1'b1;
        tmr_value  = TW'(STROBE_CYC - 1);
      end
      S_STROBE: if (tmr_done) begin
        state_next = S_HOLD;
        tmr_load   = 1'b1;
        tmr_value  = TW'(HOLD_CYC - 1);
      end
      S_HOLD:   if (tmr_done) state_next = S_NEXT;
      S_NEXT:   state_next = (op_q != OP_BCAST && pending_rest != '0) ? S_ADDR : S_DONE;
      S_DONE:   state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      op_q      <= OP_WRITE;
      addr_q    <= '0;
      mask_q    <= '0;
      wdata_q   <= '0;
      pending   <= '0;
      rsp_data  <= '0;
      rsp_count <= '0;
    end else begin
      if (accept) begin
        op_q      <= pb_op_t'(cmd_op);
        addr_q    <= cmd_addr;
        mask_q    <= cmd_mask;
        wdata_q   <= cmd_wdata;
        pending   <= cmd_mask;
        rsp_data  <= '0;
        rsp_count <= (pb_op_t'(cmd_op) == OP_BCAST && cmd_mask != '0) ? CW'(1) : mask_pop;
      end
      if (state == S_STROBE && tmr_done && is_read)
        rsp_data[int'(cur)*DATA_WIDTH +: DATA_WIDTH] <= data_in;
      if (state == S_NEXT) pending <= pending_rest;
    end
  end

  assign in_slot  = (state == S_ADDR) || (state == S_SETUP) ||
                    (state == S_STROBE) || (state == S_HOLD);
  assign is_write = (op_q == OP_WRITE) || (op_q == OP_BCAST);
  assign is_read  = (op_q == OP_READ) || (op_q == OP_TEST);

  // Address and write data stay stable through NEXT; only select and drive drop.
  always_comb begin
    lane_data = (op_q == OP_BCAST) ? wdata_q[DATA_WIDTH-1:0]
                                   : wdata_q[int'(cur)*DATA_WIDTH +: DATA_WIDTH];
    cmd_ready = (state == S_IDLE);
    busy      = (state != S_IDLE) && (state != S_DONE);
    rsp_valid = (state == S_DONE);
    board_sel = in_slot ? ((op_q == OP_BCAST) ? mask_q : cur_onehot) : '0;
    addr_port = (in_slot || state == S_NEXT) ? addr_q : '0;
    test_addr = in_slot && (op_q == OP_TEST);
    pb_wr_n   = (state == S_STROBE && (is_write || op_q == OP_TEST)) ? ENABLE : DISABLE;
    pb_rd_n   = (state == S_STROBE && is_read) ? ENABLE : DISABLE;
    data_out  = ((in_slot || state == S_NEXT) && is_write) ? lane_data : '0;
    data_oe   = in_slot && is_write;
  end

endmodule

// File: doc/pb_bus_sequencer.md
# pb_bus_sequencer

Parametrised peripheral-bus transaction engine for the lamp/ADC card backplane. It accepts one command at a time from the command decoder and walks a board mask in ascending order. For each selected board it drives board select, port address, data and active-low RD/WR strobes with setup, strobe and hold intervals derived from the clock frequency. It then returns per-board read data in a single response. It is the generalised successor of the fixed 4-board write/read/test/ADC sub-state machines, and adds a broadcast write and configurable bus timing.

## Interface
- CLOCK_FREQUENCY, 27000000, system clock in Hz
- NUM_BOARDS, 4, board slots (1..8)
- DATA_WIDTH, 8, bus data width
- ADDR_WIDTH, 3, port address width
- PRE_DELAY_NS, 0, idle time before first slot (0 = phase skipped)
- SETUP_NS, 750, address/data valid before strobe
- STROBE_NS, 750, strobe low time
- HOLD_NS, 100, address/data held after strobe release

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high
- cmd_valid  in  1  command request
- cmd_ready  out  1  high only in IDLE
- cmd_op  in  2  00 WRITE, 01 READ, 10 TEST, 11 BCAST
- cmd_addr  in  ADDR_WIDTH  port address
- cmd_mask  in  NUM_BOARDS  boards to visit
- cmd_wdata  in  NUM_BOARDS*DATA_WIDTH  lane b = data for board b
- rsp_valid  out  1  one-cycle pulse at completion
- rsp_data  out  NUM_BOARDS*DATA_WIDTH  lane b = sampled data for board b
- rsp_count  out  clog2(NUM_BOARDS+1)  boards visited
- busy  out  1  high from acceptance until rsp_valid
- board_sel  out  NUM_BOARDS  active-high select
- addr_port  out  ADDR_WIDTH  bus address
- test_addr  out  1  high for whole slot during TEST
- pb_rd_n  out  1  read strobe, active low
- pb_wr_n  out  1  write strobe, active low
- data_out  out  DATA_WIDTH  bus write data
- data_in  in  DATA_WIDTH  bus read data
- data_oe  out  1  1 = FPGA drives bus

## Operation
- Cycle counts are computed at elaboration as ceil(ns*CLOCK_FREQUENCY/1e9). SETUP_CYC, STROBE_CYC and HOLD_CYC are clamped to a minimum of 1. PRE_CYC may be 0.
- Reset and IDLE values: board_sel 0, addr_port 0, test_addr 0, pb_rd_n 1, pb_wr_n 1, data_out 0, data_oe 0, cmd_ready 1, busy 0, rsp_valid 0, rsp_data 0, rsp_count 0.
- Acceptance: cmd_valid && cmd_ready. At acceptance, op, addr, mask and wdata are latched, rsp_data is cleared, and rsp_count is set to popcount(mask). For BCAST, rsp_count is set to 1.
- States: IDLE -> PRE (if PRE_CYC>0) -> ADDR -> SETUP -> STROBE -> HOLD -> NEXT -> (next set bit ? ADDR : DONE) -> IDLE.
- ADDR (1 cycle): assert board_sel bit b and addr_port.
  - WRITE/BCAST: data_out = lane b (lane 0 for BCAST) and data_oe = 1.
  - TEST: test_addr = 1.
- SETUP: hold outputs for SETUP_CYC cycles.
- STROBE: lasts STROBE_CYC cycles.
  - WRITE/BCAST: pb_wr_n = 0.
  - READ: pb_rd_n = 0.
  - TEST: both strobes = 0.
  - READ/TEST: data_in is captured into lane b on the last STROBE cycle.
- HOLD: strobes return to 1, everything else held, for HOLD_CYC cycles.
- NEXT (1 cycle): board_sel 0, data_oe 0, test_addr 0.
- BCAST: one slot only, with board_sel = cmd_mask (all selected bits at once).
- DONE: rsp_valid = 1 for one cycle, busy drops, cmd_ready rises next cycle. rsp_data and rsp_count hold until the next acceptance.

## Timing
- Slot length = SETUP_CYC + STROBE_CYC + HOLD_CYC + 2 cycles.
- Latency from acceptance to rsp_valid = PRE_CYC + visited_slots*slot + 1 cycles.
- Empty mask: skip PRE and all slots. rsp_valid is asserted the cycle after acceptance, with rsp_count 0 and rsp_data 0.
- cmd_valid while busy is ignored. No queueing.
- data_oe never overlaps a read strobe. data_oe is 0 for READ/TEST.
- Asynchronous reset mid-transaction forces the reset values immediately. No response is issued.
- Lane order is ascending board index. Unvisited lanes read 0.

## Structure
- Package pb_bus_pkg contains:
  - op enum pb_op_t
  - state enum pb_seq_state_t
  - function ns_to_cycles(ns, freq)
  - active-low strobe constants ENABLE=0, DISABLE=1
- Sub-module pb_phase_timer: a loadable down-counter with a done flag, shared by the PRE, SETUP, STROBE and HOLD phases. Counter width is clog2 of the maximum cycle count.

## Test plan
All scenarios use CLOCK_FREQUENCY=10000000, SETUP_NS=300, STROBE_NS=200, HOLD_NS=100, PRE_DELAY_NS=0. This gives 3/2/1 cycles and an 8-cycle slot.
- WRITE, mask 4'b0101, wdata {D3,C2,B1,A0} -> board_sel 0001 then 0100, data_out A0 then C2, pb_wr_n low 2 cycles per slot, rsp_valid 17 cycles after accept, rsp_count 2.
- READ, mask 4'b1111, data_in model returns 8'h10+b -> rsp_data {13,12,11,10}, pb_wr_n stays 1, data_oe stays 0, rsp_count 4.
- TEST, mask 4'b0010 -> test_addr high 7 cycles, pb_rd_n and pb_wr_n low together for 2 cycles, lane 1 captured, other lanes 0.
- BCAST, mask 4'b1011, lane0 = 8'h5A -> single slot with board_sel 1011 and data_out 5A, rsp_count 1, latency 9 cycles.
- Empty mask -> rsp_valid the cycle after accept, rsp_count 0, no bus activity.
- Reset asserted in the STROBE phase of slot 2 -> all outputs take reset values in the same cycle, no rsp_valid, and cmd_ready is 1 after reset release.
